// File: rtl/rip_sat_counter_predictor_pkg.sv
// Shared defaults and counter-state constants for the saturating-counter branch predictors.
package rip_branch_predictor_const;

   localparam int DEF_CNT_WIDTH   = 2;
   localparam int DEF_INDEX_WIDTH = 10;
   localparam int DEF_HIST_LEN    = 10;
   localparam int DEF_PC_LSB      = 2;

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   // Highest not-taken state and lowest taken state of a cnt_w-bit counter.
   function automatic int unsigned weak_nt(input int unsigned cnt_w);
      return (32'd1 << (cnt_w - 1)) - 32'd1;
   endfunction

   function automatic int unsigned weak_t(input int unsigned cnt_w);
      return 32'd1 << (cnt_w - 1);
   endfunction

endpackage

// File: rtl/rip_sat_counter_predictor_if.sv
// Fetch/commit side bundle of the counter predictor: prediction request, prediction result, resolved update.
interface rip_sat_counter_predictor_if
   import rip_branch_predictor_const::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
   parameter int HIST_LEN    = DEF_HIST_LEN
);
   logic [31:0]            pc;
   logic                   pred;
   logic [INDEX_WIDTH-1:0] pred_index;
   logic [CNT_WIDTH-1:0]   pred_counter;
   logic [HIST_LEN-1:0]    pred_hist;
   logic                   spec_push;
   logic                   update;
   logic [INDEX_WIDTH-1:0] update_index;
   logic [CNT_WIDTH-1:0]   update_counter;
   logic [HIST_LEN-1:0]    update_hist;
   logic                   actual;
   logic                   mispredict;
   logic                   init_done;

   modport master (
      output pc, spec_push, update, update_index, update_counter, update_hist, actual, mispredict,
      input  pred, pred_index, pred_counter, pred_hist, init_done
   );

   modport slave (
      input  pc, spec_push, update, update_index, update_counter, update_hist, actual, mispredict,
      output pred, pred_index, pred_counter, pred_hist, init_done
   );

endinterface

// File: rtl/rip_sat_counter_predictor_bram.sv
// Counter table: port 1 write, port 2 registered read, read-first on address collision.
module rip_2r1w_bram #(
   parameter int DATA_W = 2,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_dat_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_dat_o
);
   logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] rd_dat_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   // Both blocks sample on the same edge, so a colliding read returns the old entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_dat_q <= '0;
      end else begin
         rd_dat_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/rip_sat_counter_predictor.sv
// Saturating-counter branch predictor, one-cycle prediction; bimodal by default, gshare with RIP_BP_GSHARE_EN.
// Table is swept to weakly not-taken after reset; updates and history changes are ignored until init_done.
module rip_sat_counter_predictor
   import rip_branch_predictor_const::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
   parameter int HIST_LEN    = DEF_HIST_LEN,
   parameter int PC_LSB      = DEF_PC_LSB
) (
   input logic                       clk,
   input logic                       rstn,
   rip_sat_counter_predictor_if.slave bp
);
   localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0]   CNT_WNT  = CNT_WIDTH'(weak_nt(CNT_WIDTH));
   localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;

   logic [0:0]             state_q, state_d;
   logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
   logic [HIST_LEN-1:0]    hist_cur;
   logic [INDEX_WIDTH-1:0] pred_index_q;
   logic [HIST_LEN-1:0]    pred_hist_q;
   logic [INDEX_WIDTH-1:0] rd_index;
   logic [CNT_WIDTH-1:0]   rd_cnt;
   logic [CNT_WIDTH-1:0]   upd_cnt;
   logic                   ready;
   logic                   wr_en;
   logic [INDEX_WIDTH-1:0] wr_addr;
   logic [CNT_WIDTH-1:0]   wr_dat;
   logic                   unused_pc;

   assign ready     = (state_q == ST_READY);
   assign rd_index  = bp.pc[PC_LSB +: INDEX_WIDTH] ^ INDEX_WIDTH'(hist_cur);
   assign unused_pc = ^bp.pc;

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (state_q == ST_INIT) begin
         sweep_d = sweep_q + 1'b1;
         if (sweep_q == IDX_LAST) begin
            state_d = ST_READY;
         end
      end
   end

   always_comb begin
      upd_cnt = bp.update_counter;
      if (bp.actual) begin
         if (bp.update_counter != CNT_MAX) begin
            upd_cnt = bp.update_counter + 1'b1;
         end
      end else if (bp.update_counter != '0) begin
         upd_cnt = bp.update_counter - 1'b1;
      end
   end

   // The sweep owns the write port until the table is initialised.
   assign wr_en   = ready ? bp.update       : 1'b1;
   assign wr_addr = ready ? bp.update_index : sweep_q;
   assign wr_dat  = ready ? upd_cnt         : CNT_WNT;

`ifdef RIP_BP_GSHARE_EN
   logic [HIST_LEN-1:0] hist_q, hist_d;

   // Truncating {hist, bit} to HIST_LEN also covers the single-bit history case.
   always_comb begin
      hist_d = hist_q;
      if (ready) begin
         if (bp.update && bp.mispredict) begin
            hist_d = HIST_LEN'({bp.update_hist, bp.actual});
         end else if (bp.spec_push) begin
            hist_d = HIST_LEN'({hist_q, bp.pred});
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign hist_cur = hist_q;
`else
   logic unused_gshare;

   assign hist_cur      = '0;
   assign unused_gshare = ^{bp.spec_push, bp.mispredict, bp.update_hist};
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_INIT;
         sweep_q      <= '0;
         pred_index_q <= '0;
         pred_hist_q  <= '0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         pred_index_q <= rd_index;
         pred_hist_q  <= hist_cur;
      end
   end

   rip_2r1w_bram #(
      .DATA_W (CNT_WIDTH),
      .ADDR_W (INDEX_WIDTH)
   ) u_bram (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_dat_i  (wr_dat),
      .rd_addr_i (rd_index),
      .rd_dat_o  (rd_cnt)
   );

   assign bp.pred         = ready & rd_cnt[CNT_WIDTH-1];
   assign bp.pred_index   = pred_index_q;
   assign bp.pred_counter = rd_cnt;
   assign bp.pred_hist    = pred_hist_q;
   assign bp.init_done    = ready;

endmodule

// File: tb/tb_rip_sat_counter_predictor.sv
// Directed bench for rip_sat_counter_predictor with a reference table and a prediction scoreboard.
module tb_rip_sat_counter_predictor;
   import rip_branch_predictor_const::*;

   localparam int CW = DEF_CNT_WIDTH;
   localparam int IW = DEF_INDEX_WIDTH;
   localparam int HL = DEF_HIST_LEN;
   localparam int PL = DEF_PC_LSB;
`ifdef RIP_BP_GSHARE_EN
   localparam bit GS = 1'b1;
`else
   localparam bit GS = 1'b0;
`endif

   typedef struct {
      int idx;
      int cnt;
      int pred;
      int hist;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   exp_t sb[$];
   int   tbl[1024];
   bit   m_ready;
   int   n_vec;
   int   n_err;

   always #5 clk = ~clk;

   rip_sat_counter_predictor_if #(.CNT_WIDTH(CW), .INDEX_WIDTH(IW), .HIST_LEN(HL)) bp ();

   rip_sat_counter_predictor #(
      .CNT_WIDTH   (CW),
      .INDEX_WIDTH (IW),
      .HIST_LEN    (HL),
      .PC_LSB      (PL)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bp   (bp)
   );

   function automatic int sat_next(input int c, input bit a);
      if (a) return (c == (1 << CW) - 1) ? c : c + 1;
      return (c == 0) ? 0 : c - 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_init_done"}, bp.init_done, 0);
      check({tag, "_pred"}, bp.pred, 0);
      check({tag, "_pred_index"}, bp.pred_index, 0);
      check({tag, "_pred_counter"}, bp.pred_counter, 0);
      check({tag, "_pred_hist"}, bp.pred_hist, 0);
   endtask

   task automatic issue(input int pidx, input int hist);
      exp_t e;
      bp.pc  = 32'(pidx) << PL;
      e.idx  = pidx ^ hist;
      e.cnt  = tbl[e.idx];
      e.pred = (e.cnt >> (CW - 1)) & 1;
      e.hist = hist;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check("pred_index", bp.pred_index, e.idx);
         check("pred_counter", bp.pred_counter, e.cnt);
         check("pred", bp.pred, e.pred);
         check("pred_hist", bp.pred_hist, e.hist);
      end
   endtask

   task automatic upd(input int idx, input int cnt, input bit act, input bit misp, input int uhist);
      bp.update         = 1'b1;
      bp.update_index   = idx[IW-1:0];
      bp.update_counter = cnt[CW-1:0];
      bp.actual         = act;
      bp.mispredict     = misp;
      bp.update_hist    = uhist[HL-1:0];
      if (m_ready) tbl[idx] = sat_next(cnt, act);
   endtask

   task automatic upd_off();
      bp.update     = 1'b0;
      bp.mispredict = 1'b0;
      bp.spec_push  = 1'b0;
   endtask

   // Starts just after rstn release; pokes updates/history controls mid-sweep when asked.
   task automatic run_init(input bit poke);
      m_ready = 1'b0;
      check("init_done_cycle1", bp.init_done, 0);
      for (int c = 1; c < 1024; c++) begin
         if (poke && c == 10) begin
            bp.spec_push = 1'b1;
            upd(2, 3, 1'b1, 1'b1, 10'b101);
         end
         if (poke && c == 13) upd_off();
         tick();
         check("init_done_low", bp.init_done, 0);
      end
      tick();
      check("init_done_high", bp.init_done, 1);
      for (int i = 0; i < 1024; i++) tbl[i] = 1;
      m_ready = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_ready = 1'b0;
      bp.pc = '0;
      bp.update_index = '0;
      bp.update_counter = '0;
      bp.update_hist = '0;
      bp.actual = 1'b0;
      upd_off();

      #12;
      check_reset("reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      run_init(1'b1);

      // Whole table must read weakly not-taken, untouched by the mid-sweep update.
      for (int i = 0; i < 1024; i++) begin
         issue(i, 0);
         tick();
      end

      // Count up on entry 5, including a read colliding with the write.
      upd(5, tbl[5], 1'b1, 1'b0, 0);
      tick();
      upd_off();
      issue(5, 0);
      tick();
      issue(5, 0);
      upd(5, tbl[5], 1'b1, 1'b0, 0);
      tick();
      upd_off();
      issue(5, 0);
      tick();
      upd(5, tbl[5], 1'b1, 1'b0, 0);
      tick();
      upd_off();
      issue(5, 0);
      tick();

      // Count down on entry 7 and saturate at zero.
      upd(7, tbl[7], 1'b0, 1'b0, 0);
      tick();
      upd_off();
      issue(7, 0);
      tick();
      upd(7, tbl[7], 1'b0, 1'b0, 0);
      tick();
      upd_off();
      issue(7, 0);
      tick();

      // Two speculative pushes of a taken prediction.
      issue(5, 0);
      tick();
      bp.spec_push = 1'b1;
      issue(5, 0);
      tick();
      issue(5, GS ? 1 : 0);
      tick();
      bp.spec_push = 1'b0;
      issue(5, GS ? 3 : 0);
      tick();

      // Mispredict restore wins over a same-cycle push.
      bp.spec_push = 1'b1;
      upd(9, tbl[9], 1'b0, 1'b1, 10'b101);
      tick();
      upd_off();
      issue(0, GS ? 10 : 0);
      tick();
      issue(9 ^ (GS ? 10 : 0), GS ? 10 : 0);
      tick();

      // Reset in READY, then again at sweep index 300.
      bp.pc = 32'hFFC;
      rstn = 1'b0;
      #2;
      check_reset("reset_ready");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int c = 0; c < 300; c++) tick();
      check("pred_index_in_init", bp.pred_index, 1023);
      rstn = 1'b0;
      #2;
      check_reset("reset_mid_init");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      run_init(1'b0);

      issue(5, 0);
      tick();
      issue(7, 0);
      tick();
      issue(9, 0);
      tick();
      issue(10, 0);
      tick();
      issue(1023, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
